// File: rtl/blake2_pkg.sv
// Shared constants and fill-state type for the BLAKE2s message loader.
// Optional double buffering is selected with BLAKE2_LOADER_DBUF_EN.
package blake2_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int WORD_W      = 32;
    localparam int NWORDS      = 16;
    localparam int T_W         = 64;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_t;

endpackage

// File: rtl/blake2_msg_loader_if.sv
// Byte-stream and block-read bus between the pin logic, the loader
// and the compression engine.
interface blake2_msg_loader_if #(
    parameter int T_W = 64
);
    logic [7:0]     data_i;
    logic           data_valid_i;
    logic           data_last_i;
    logic           data_ready_o;
    logic           msg_empty_i;
    logic           blk_valid_o;
    logic           blk_last_o;
    logic [T_W-1:0] blk_t_o;
    logic [3:0]     blk_idx_i;
    logic [31:0]    blk_word_o;
    logic           blk_done_i;

    modport master (
        output data_i, data_valid_i, data_last_i, msg_empty_i,
        output blk_idx_i, blk_done_i,
        input  data_ready_o, blk_valid_o, blk_last_o, blk_t_o,
        input  blk_word_o
    );

    modport slave (
        input  data_i, data_valid_i, data_last_i, msg_empty_i,
        input  blk_idx_i, blk_done_i,
        output data_ready_o, blk_valid_o, blk_last_o, blk_t_o,
        output blk_word_o
    );
endinterface

// File: rtl/blake2_blk_buf.sv
// One 16 x 32-bit message bank: little-endian byte writes,
// synchronous clear, combinational word read.
module blake2_blk_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_we,
    input  logic [5:0]  i_addr,
    input  logic [7:0]  i_data,
    input  logic [3:0]  i_idx,
    output logic [31:0] o_word
);
    logic [31:0] r_mem [16];

    // Bank storage; clear wins so a released bank reads as zero padding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (i_clr) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_addr[5:2]][{i_addr[1:0], 3'b000} +: 8] <= i_data;
        end
    end

    assign o_word = r_mem[i_idx];

endmodule

// File: rtl/blake2_msg_loader.sv
// Packs the message byte stream into BLAKE2s blocks for the core.
// Define BLAKE2_LOADER_DBUF_EN for two ping-pong banks.
module blake2_msg_loader #(
    parameter int BLOCK_BYTES = blake2_pkg::BLOCK_BYTES,
    parameter int T_W         = blake2_pkg::T_W
) (
    input  logic               clk,
    input  logic               rst,
    blake2_msg_loader_if.slave bus
);
    import blake2_pkg::*;

`ifdef BLAKE2_LOADER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    fill_state_t    r_st [2];
    fill_state_t    w_st_nxt [2];
    logic           r_wr;
    logic           r_rd;
    logic [6:0]     r_cnt;
    logic [T_W-1:0] r_t;
    logic [T_W-1:0] r_bt [2];
    logic           r_bl [2];
    logic [31:0]    w_word [2];

    logic w_accept;
    logic w_complete;
    logic w_empty;
    logic w_done;

    assign w_accept   = bus.data_valid_i & bus.data_ready_o;
    assign w_complete = w_accept &
                        (bus.data_last_i |
                         (r_cnt == 7'(BLOCK_BYTES - 1)));
    assign w_empty    = bus.msg_empty_i & ~bus.data_valid_i &
                        (r_st[r_wr] == FILL) & (r_t == '0);
    assign w_done     = bus.blk_done_i & bus.blk_valid_o;

    assign bus.data_ready_o = (r_st[r_wr] == FILL);
    assign bus.blk_valid_o  = (r_st[r_rd] == HOLD);
    assign bus.blk_last_o   = r_bl[r_rd];
    assign bus.blk_t_o      = r_bt[r_rd];
    assign bus.blk_word_o   = w_word[r_rd];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b == 0 || DBUF) begin : g_on
            blake2_blk_buf u_buf (
                .clk    (clk),
                .rst    (rst),
                .i_clr  (w_done & (r_rd == 1'(b))),
                .i_we   (w_accept & (r_wr == 1'(b))),
                .i_addr (r_cnt[5:0]),
                .i_data (bus.data_i),
                .i_idx  (bus.blk_idx_i),
                .o_word (w_word[b])
            );
        end else begin : g_off
            assign w_word[b] = '0;
        end
    end

    // Per-bank fill state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st <= '{default: FILL};
        end else begin
            r_st <= w_st_nxt;
        end
    end

    // Fill bank closes on a completed block; read bank opens on release.
    always_comb begin
        w_st_nxt = r_st;
        if (w_complete || w_empty) begin
            w_st_nxt[r_wr] = HOLD;
        end
        if (w_done) begin
            w_st_nxt[r_rd] = FILL;
        end
    end

    // Counters, per-bank t/last snapshots and bank pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_t   <= '0;
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_bt  <= '{default: '0};
            r_bl  <= '{default: 1'b0};
        end else begin
            if (w_accept) begin
                r_cnt <= w_complete ? 7'd0 : r_cnt + 7'd1;
                r_t   <= (w_complete && bus.data_last_i) ?
                         '0 : r_t + T_W'(1);
            end
            if (w_complete || w_empty) begin
                r_bt[r_wr] <= w_empty ? '0 : r_t + T_W'(1);
                r_bl[r_wr] <= w_empty | bus.data_last_i;
                r_wr       <= r_wr ^ DBUF;
            end
            if (w_done) begin
                r_bt[r_rd] <= '0;
                r_bl[r_rd] <= 1'b0;
                r_rd       <= r_rd ^ DBUF;
            end
        end
    end

endmodule
